// File: rtl/clock_div_pkg.sv
// Shared types and constants for the multi-channel clock/tick divider.
// Build option: define CLKDIV_SYNC_EN to add the global phase-align input.
package clock_div_pkg;

    localparam int DIV_W_DEFAULT     = 32;
    localparam int DEFAULT_DIV_500MS = 25000000;

    typedef logic [DIV_W_DEFAULT-1:0] div_t;

    // Select width for a channel index; never narrower than one bit
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: half-period counter with registered tick and square-wave outputs.
// Build option: CLKDIV_SYNC_EN adds a sync input that clears counter and clk_out.
module clock_div_ch
    import clock_div_pkg::*;
#(
    parameter int   DIV_W       = DIV_W_DEFAULT,
    parameter div_t DEFAULT_DIV = div_t'(DEFAULT_DIV_500MS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             tick,
    output logic             clk_out
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             tick_q;
    logic             clk_out_q;
    logic             terminal;

    // div_q is never zero, so div_q-1 cannot wrap
    assign terminal = (cnt_q == (div_q - DIV_W'(1)));

    // A write takes priority over counting, so a terminal count on the
    // load cycle is swallowed; sync (when built) overrides both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= DIV_W'(DEFAULT_DIV);
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (wr) begin
                div_q <= (wr_div == '0) ? DIV_W'(1) : wr_div;
                cnt_q <= '0;
            end else if (en) begin
                if (terminal) begin
                    cnt_q     <= '0;
                    tick_q    <= 1'b1;
                    clk_out_q <= ~clk_out_q;
                end else begin
                    cnt_q <= cnt_q + DIV_W'(1);
                end
            end
`ifdef CLKDIV_SYNC_EN
            if (sync) begin
                cnt_q     <= '0;
                tick_q    <= 1'b0;
                clk_out_q <= 1'b0;
            end
`endif
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_out_q;

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable divider: load decode, per-channel instances, write handshake.
// Build option: CLKDIV_SYNC_EN adds the sync port that phase-aligns all channels.
module clock_div_multi
    import clock_div_pkg::*;
#(
    parameter int   NUM_CH      = 4,
    parameter int   DIV_W       = DIV_W_DEFAULT,
    parameter div_t DEFAULT_DIV = div_t'(DEFAULT_DIV_500MS),
    localparam int  CH_W        = clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              load,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [DIV_W-1:0]  load_div,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync,
`endif
    output logic              load_ack,
    output logic              load_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    logic              ch_valid;
    logic [NUM_CH-1:0] wr_vec;
    logic              load_ack_q;
    logic              load_err_q;

    assign ch_valid = (int'(load_ch) < NUM_CH);

    // Out-of-range writes reach no channel and only raise load_err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_ack_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            load_ack_q <= load && ch_valid;
            load_err_q <= load && !ch_valid;
        end
    end

    assign load_ack = load_ack_q;
    assign load_err = load_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_vec[i] = load && ch_valid && (load_ch == CH_W'(i));

        clock_div_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .wr      (wr_vec[i]),
            .wr_div  (load_div),
`ifdef CLKDIV_SYNC_EN
            .sync    (sync),
`endif
            .tick    (tick[i]),
            .clk_out (clk_out[i])
        );
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Self-checking bench for clock_div_multi against an elapsed-cycle reference model.
// Honours CLKDIV_SYNC_EN when the design is built with it.
module tb_clock_div_multi;

    localparam int NUM_CH  = 3;
    localparam int CH_W    = 2;
    localparam int DIV_W   = 32;
    localparam int DEF_DIV = 4;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic [NUM_CH-1:0] en       = '0;
    logic              load     = 1'b0;
    logic [CH_W-1:0]   load_ch  = '0;
    logic [DIV_W-1:0]  load_div = '0;
    logic              sync_in  = 1'b0;
    logic              load_ack;
    logic              load_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: enabled cycles since the last realignment, ticking
    // whenever that count reaches a multiple of the divisor.
    int                m_div[NUM_CH];
    int                m_elapsed[NUM_CH];
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_clk;
    logic              m_ack;
    logic              m_err;

    clock_div_multi #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_ch  (load_ch),
        .load_div (load_div),
`ifdef CLKDIV_SYNC_EN
        .sync     (sync_in),
`endif
        .load_ack (load_ack),
        .load_err (load_err),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]     = DEF_DIV;
            m_elapsed[i] = 0;
        end
        m_tick = '0;
        m_clk  = '0;
        m_ack  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        m_ack = load && (int'(load_ch) < NUM_CH);
        m_err = load && !(int'(load_ch) < NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            m_tick[i] = 1'b0;
            if (load && int'(load_ch) == i) begin
                m_div[i]     = (load_div == '0) ? 1 : int'(load_div);
                m_elapsed[i] = 0;
            end else if (en[i]) begin
                m_elapsed[i]++;
                if (m_elapsed[i] % m_div[i] == 0) begin
                    m_tick[i] = 1'b1;
                    m_clk[i]  = ~m_clk[i];
                end
            end
            if (sync_in) begin
                m_elapsed[i] = 0;
                m_tick[i]    = 1'b0;
                m_clk[i]     = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        load    = 1'b0;
        en      = '0;
        sync_in = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        int count;
        first = 0;
        count = 0;
        model_reset();
        step();
        n_cmp++;
        if ({load_err, load_ack, clk_out, tick} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_values got %b want 0", {load_err, load_ack, clk_out, tick});
        end
        rst = 1'b0;
        en  = '1;
        for (int c = 1; c <= 20; c++) begin
            step();
            n_cmp++;
            if ({load_err, load_ack, clk_out, tick} !== {m_err, m_ack, m_clk, m_tick}) begin
                n_fail++;
                $display("[TB] FAIL reset_run cyc=%0d err/ack/clk_out/tick got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, load_err, load_ack, clk_out, tick, m_err, m_ack, m_clk, m_tick);
            end
            if (tick[0] === 1'b1) begin
                count++;
                if (first == 0) first = c;
            end
        end
        n_cmp++;
        if (first != 4 || count != 5) begin
            n_fail++;
            $display("[TB] FAIL reset_cadence got first=%0d count=%0d want first=4 count=5", first, count);
        end
    endtask

    task automatic test_reprogram();
        int first;
        int count;
        first = 0;
        count = 0;
        do_reset();
        en = '1;
        step();
        step();
        load     = 1'b1;
        load_ch  = 2'd1;
        load_div = 3;
        step();
        load = 1'b0;
        n_cmp++;
        if (load_ack !== 1'b1 || tick[1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reprogram_ack got ack=%b tick1=%b want ack=1 tick1=0", load_ack, tick[1]);
        end
        for (int c = 1; c <= 9; c++) begin
            step();
            n_cmp++;
            if ({load_err, load_ack, clk_out, tick} !== {m_err, m_ack, m_clk, m_tick}) begin
                n_fail++;
                $display("[TB] FAIL reprogram_run cyc=%0d err/ack/clk_out/tick got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, load_err, load_ack, clk_out, tick, m_err, m_ack, m_clk, m_tick);
            end
            if (tick[1] === 1'b1) begin
                count++;
                if (first == 0) first = c;
            end
        end
        n_cmp++;
        if (first != 3 || count != 3) begin
            n_fail++;
            $display("[TB] FAIL reprogram_cadence got first=%0d count=%0d want first=3 count=3", first, count);
        end
    endtask

    task automatic test_edge_loads();
        do_reset();
        en       = '1;
        load     = 1'b1;
        load_ch  = 2'd0;
        load_div = 0;
        step();
        load = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            n_cmp++;
            if (tick[0] !== 1'b1 || {clk_out, tick} !== {m_clk, m_tick}) begin
                n_fail++;
                $display("[TB] FAIL div_zero cyc=%0d clk_out/tick got %b/%b want %b/%b",
                         cyc, clk_out, tick, m_clk, m_tick);
            end
        end
        load     = 1'b1;
        load_ch  = 2'd3;
        load_div = 7;
        step();
        load = 1'b0;
        n_cmp++;
        if (load_err !== 1'b1 || load_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bad_channel got err=%b ack=%b want err=1 ack=0", load_err, load_ack);
        end
        for (int c = 1; c <= 12; c++) begin
            step();
            n_cmp++;
            if ({load_err, load_ack, clk_out, tick} !== {m_err, m_ack, m_clk, m_tick}) begin
                n_fail++;
                $display("[TB] FAIL bad_channel_run cyc=%0d err/ack/clk_out/tick got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, load_err, load_ack, clk_out, tick, m_err, m_ack, m_clk, m_tick);
            end
        end
    endtask

    task automatic test_enable_gating();
        int first;
        first = 0;
        do_reset();
        en = '1;
        step();
        en[0] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            n_cmp++;
            if (tick[0] !== 1'b0 || {clk_out, tick} !== {m_clk, m_tick}) begin
                n_fail++;
                $display("[TB] FAIL gated cyc=%0d clk_out/tick got %b/%b want %b/%b",
                         cyc, clk_out, tick, m_clk, m_tick);
            end
        end
        en[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (tick[0] === 1'b1 && first == 0) first = c;
        end
        n_cmp++;
        if (first != 3) begin
            n_fail++;
            $display("[TB] FAIL reenable_first_tick got %0d want 3", first);
        end
    endtask

    task automatic test_async_reset();
        int first;
        first = 0;
        do_reset();
        en       = '1;
        load     = 1'b1;
        load_ch  = 2'd0;
        load_div = 3;
        step();
        load = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_cmp++;
            if ({load_err, load_ack, clk_out, tick} !== {m_err, m_ack, m_clk, m_tick}) begin
                n_fail++;
                $display("[TB] FAIL pre_reset cyc=%0d err/ack/clk_out/tick got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, load_err, load_ack, clk_out, tick, m_err, m_ack, m_clk, m_tick);
            end
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({load_err, load_ack, clk_out, tick} !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_reset got %b want 0", {load_err, load_ack, clk_out, tick});
        end
        step();
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (tick[0] === 1'b1 && first == 0) first = c;
        end
        n_cmp++;
        if (first != DEF_DIV) begin
            n_fail++;
            $display("[TB] FAIL divisor_reverted got first tick %0d want %0d", first, DEF_DIV);
        end
    endtask

`ifdef CLKDIV_SYNC_EN
    task automatic test_sync();
        int first0;
        int first1;
        first0 = 0;
        first1 = 0;
        do_reset();
        en       = '1;
        load     = 1'b1;
        load_ch  = 2'd1;
        load_div = 6;
        step();
        load = 1'b0;
        for (int c = 1; c <= 5; c++) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        n_cmp++;
        if (tick !== '0 || clk_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL sync_clear got tick=%b clk_out=%b want 0/0", tick, clk_out);
        end
        for (int c = 1; c <= 7; c++) begin
            step();
            if (tick[0] === 1'b1 && first0 == 0) first0 = c;
            if (tick[1] === 1'b1 && first1 == 0) first1 = c;
        end
        n_cmp++;
        if (first0 != 4 || first1 != 6) begin
            n_fail++;
            $display("[TB] FAIL sync_realign got ch0=%0d ch1=%0d want 4/6", first0, first1);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            en       = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            load     = ($urandom_range(0, 7) == 0);
            load_ch  = CH_W'($urandom_range(0, 3));
            load_div = DIV_W'($urandom_range(0, 6));
`ifdef CLKDIV_SYNC_EN
            sync_in  = ($urandom_range(0, 39) == 0);
`endif
            step();
            n_cmp++;
            if ({load_err, load_ack, clk_out, tick} !== {m_err, m_ack, m_clk, m_tick}) begin
                n_fail++;
                $display("[TB] FAIL random cyc=%0d err/ack/clk_out/tick got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, load_err, load_ack, clk_out, tick, m_err, m_ack, m_clk, m_tick);
            end
        end
        rst     = 1'b0;
        load    = 1'b0;
        sync_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reprogram();
        test_edge_loads();
        test_enable_gating();
        test_async_reset();
`ifdef CLKDIV_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
